// File: rtl/pc_gen_pkg.sv
// Shared constants and helpers for the IF-stage PC generator and its BTB.
package pc_gen_pkg;

    localparam int unsigned INST_BYTES = 4;

    localparam logic [1:0] BTB_CTR_SN = 2'b00;
    localparam logic [1:0] BTB_CTR_WT = 2'b10;
    localparam logic [1:0] BTB_CTR_ST = 2'b11;

    // Saturating 2-bit direction counter step.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == BTB_CTR_ST) ? ctr : ctr + 2'b01;
        end
        return (ctr == BTB_CTR_SN) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the PC generator: stall, fetch handshake, EX redirect and BTB update.
interface pc_gen_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned STALL_W = 3
);
    logic [STALL_W-1:0] stall_in;
    logic               fetch_ready_in;
    logic               redirect_valid_in;
    logic [XLEN-1:0]    redirect_pc_in;
    logic               btb_upd_valid_in;
    logic [XLEN-1:0]    btb_upd_pc_in;
    logic [XLEN-1:0]    btb_upd_tar_in;
    logic               btb_upd_taken_in;
    logic               fetch_valid_out;
    logic [XLEN-1:0]    fetch_pc_out;
    logic               fetch_pred_taken_out;
    logic [XLEN-1:0]    fetch_pred_tar_out;

    modport master (
        input  stall_in, fetch_ready_in, redirect_valid_in, redirect_pc_in,
               btb_upd_valid_in, btb_upd_pc_in, btb_upd_tar_in, btb_upd_taken_in,
        output fetch_valid_out, fetch_pc_out, fetch_pred_taken_out, fetch_pred_tar_out
    );

    modport slave (
        output stall_in, fetch_ready_in, redirect_valid_in, redirect_pc_in,
               btb_upd_valid_in, btb_upd_pc_in, btb_upd_tar_in, btb_upd_taken_in,
        input  fetch_valid_out, fetch_pc_out, fetch_pred_taken_out, fetch_pred_tar_out
    );

endinterface

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous update,
// 2-bit saturating direction counters. Lookup always sees pre-update contents.
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [XLEN-1:0] lkp_pc_in,
    output logic            lkp_taken_out,
    output logic [XLEN-1:0] lkp_tar_out,
    input  logic            upd_en_in,
    input  logic [XLEN-1:0] upd_pc_in,
    input  logic [XLEN-1:0] upd_tar_in,
    input  logic            upd_taken_in
);
    localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - IDXW - 2;

    logic [BTB_ENTRIES-1:0]           valid_q, valid_d;
    logic [BTB_ENTRIES-1:0][TAGW-1:0] tag_q, tag_d;
    logic [BTB_ENTRIES-1:0][XLEN-1:0] tar_q, tar_d;
    logic [BTB_ENTRIES-1:0][1:0]      ctr_q, ctr_d;

    // Word addresses; the byte offset inside an instruction never selects an entry.
    logic [XLEN-3:0] lkp_w, upd_w;
    logic [IDXW-1:0] lkp_idx, upd_idx;
    logic            lkp_hit, upd_hit;

    assign lkp_w   = (XLEN-2)'(lkp_pc_in >> 2);
    assign upd_w   = (XLEN-2)'(upd_pc_in >> 2);
    assign lkp_idx = lkp_w[IDXW-1:0];
    assign upd_idx = upd_w[IDXW-1:0];
    assign lkp_hit = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_w[XLEN-3:IDXW]);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_w[XLEN-3:IDXW]);

    assign lkp_taken_out = lkp_hit && ctr_q[lkp_idx][1];
    assign lkp_tar_out   = tar_q[lkp_idx];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tar_d   = tar_q;
        ctr_d   = ctr_q;
        if (upd_en_in) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], upd_taken_in);
                if (upd_taken_in) begin
                    tar_d[upd_idx] = upd_tar_in;
                end
            end else if (upd_taken_in) begin
                valid_d[upd_idx] = 1'b1;
                tag_d[upd_idx]   = upd_w[XLEN-3:IDXW];
                tar_d[upd_idx]   = upd_tar_in;
                ctr_d[upd_idx]   = BTB_CTR_WT;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_q <= '0;
            ctr_q   <= {BTB_ENTRIES{BTB_CTR_SN}};
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tar_q   <= tar_d;
            ctr_q   <= ctr_d;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// IF-stage next-PC generator: registered fetch offer with valid/ready handshake,
// EX redirect flush, and BTB-driven next-PC prediction.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter int unsigned     STALL_W     = 3
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    pc_gen_if.master  fetch_if
);
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic            ptaken_q, ptaken_d;
    logic [XLEN-1:0] ptar_q, ptar_d;

    logic            lkp_taken;
    logic [XLEN-1:0] lkp_tar;
    logic            adv;

    pc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .lkp_pc_in     (pc_q),
        .lkp_taken_out (lkp_taken),
        .lkp_tar_out   (lkp_tar),
        .upd_en_in     (rdy_in && fetch_if.btb_upd_valid_in),
        .upd_pc_in     (fetch_if.btb_upd_pc_in),
        .upd_tar_in    (fetch_if.btb_upd_tar_in),
        .upd_taken_in  (fetch_if.btb_upd_taken_in)
    );

    assign adv = rdy_in && (fetch_if.stall_in == STALL_W'(0))
                 && (!valid_q || fetch_if.fetch_ready_in);

    // Redirect outranks issue so a flushed offer is never replaced by a stale PC.
    always_comb begin
        pc_d     = pc_q;
        valid_d  = valid_q;
        fpc_d    = fpc_q;
        ptaken_d = ptaken_q;
        ptar_d   = ptar_q;
        if (rdy_in && fetch_if.redirect_valid_in) begin
            valid_d = 1'b0;
            pc_d    = fetch_if.redirect_pc_in & ~XLEN'(INST_BYTES - 1);
        end else if (adv) begin
            valid_d  = 1'b1;
            fpc_d    = pc_q;
            ptaken_d = lkp_taken;
            ptar_d   = lkp_tar;
            pc_d     = lkp_taken ? lkp_tar : pc_q + XLEN'(INST_BYTES);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            fpc_q    <= RESET_PC;
            ptaken_q <= 1'b0;
            ptar_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            fpc_q    <= fpc_d;
            ptaken_q <= ptaken_d;
            ptar_q   <= ptar_d;
        end
    end

    assign fetch_if.fetch_valid_out      = valid_q;
    assign fetch_if.fetch_pc_out         = fpc_q;
    assign fetch_if.fetch_pred_taken_out = ptaken_q;
    assign fetch_if.fetch_pred_tar_out   = ptar_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed stimulus pushes expected fetches, a negedge
// monitor pops and compares on every accepted fetch.
module tb_pc_gen;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tar;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    pc_gen_if #(.XLEN(32), .STALL_W(3)) f0 ();
    pc_gen_if #(.XLEN(32), .STALL_W(3)) f1 ();

    pc_gen #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .BTB_ENTRIES(16), .STALL_W(3)
    ) dut0 (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .fetch_if(f0)
    );

    pc_gen #(
        .XLEN(32), .RESET_PC(32'hFFFF_FFFC), .BTB_ENTRIES(16), .STALL_W(3)
    ) dut1 (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .fetch_if(f1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic taken, input logic [31:0] tar);
        exp_t e;
        e.pc = pc; e.taken = taken; e.tar = tar;
        sb_q.push_back(e);
    endtask

    task automatic redirect(input logic [31:0] pc);
        f0.redirect_valid_in = 1'b1;
        f0.redirect_pc_in    = pc;
        tick();
        f0.redirect_valid_in = 1'b0;
    endtask

    task automatic btb_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tar);
        f0.btb_upd_valid_in = 1'b1;
        f0.btb_upd_pc_in    = pc;
        f0.btb_upd_taken_in = taken;
        f0.btb_upd_tar_in   = tar;
        tick();
        f0.btb_upd_valid_in = 1'b0;
    endtask

    // From an empty offer, let two fetches be accepted, then park the third.
    task automatic run3();
        f0.fetch_ready_in = 1'b1;
        repeat (3) tick();
        f0.fetch_ready_in = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && rdy && f0.fetch_valid_out && f0.fetch_ready_in
            && f0.stall_in == 3'b000 && !f0.redirect_valid_in) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_fetch: got pc %h expected no fetch", f0.fetch_pc_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("fetch_pc", f0.fetch_pc_out, e.pc);
                check("pred_taken", 32'(f0.fetch_pred_taken_out), 32'(e.taken));
                if (e.taken) check("pred_tar", f0.fetch_pred_tar_out, e.tar);
            end
        end
    end

    initial begin
        f0.stall_in = 3'b000; f0.fetch_ready_in = 1'b1;
        f0.redirect_valid_in = 1'b0; f0.redirect_pc_in = '0;
        f0.btb_upd_valid_in = 1'b0; f0.btb_upd_pc_in = '0;
        f0.btb_upd_tar_in = '0; f0.btb_upd_taken_in = 1'b0;
        f1.stall_in = 3'b000; f1.fetch_ready_in = 1'b1;
        f1.redirect_valid_in = 1'b0; f1.redirect_pc_in = '0;
        f1.btb_upd_valid_in = 1'b0; f1.btb_upd_pc_in = '0;
        f1.btb_upd_tar_in = '0; f1.btb_upd_taken_in = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_valid", 32'(f0.fetch_valid_out), 32'd0);
        check("rst_pc", f0.fetch_pc_out, 32'h0);
        check("rst_taken", 32'(f0.fetch_pred_taken_out), 32'd0);
        check("rst_tar", f0.fetch_pred_tar_out, 32'h0);
        check("rst_pc_vec", f1.fetch_pc_out, 32'hFFFF_FFFC);
        check("rst_valid_vec", 32'(f1.fetch_valid_out), 32'd0);

        // T1 sequential stepping, plus reset-vector wrap on the second instance
        push(32'h0, 1'b0, 32'h0);
        push(32'h4, 1'b0, 32'h0);
        push(32'h8, 1'b0, 32'h0);
        push(32'hC, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        check("vec_first_pc", f1.fetch_pc_out, 32'hFFFF_FFFC);
        check("vec_first_valid", 32'(f1.fetch_valid_out), 32'd1);
        tick();
        check("vec_wrap_pc", f1.fetch_pc_out, 32'h0);
        tick();
        f0.fetch_ready_in = 1'b0;

        // T2 backpressure holds the offer
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_pc", f0.fetch_pc_out, 32'h8);
            check("hold_valid", 32'(f0.fetch_valid_out), 32'd1);
        end
        f0.fetch_ready_in = 1'b1;
        repeat (2) tick();

        // T3 redirect under stall, low target bits dropped
        f0.fetch_ready_in = 1'b0;
        f0.stall_in = 3'b010;
        redirect(32'h102);
        check("redir_bubble", 32'(f0.fetch_valid_out), 32'd0);
        tick();
        check("stall_bubble", 32'(f0.fetch_valid_out), 32'd0);
        f0.stall_in = 3'b000;
        push(32'h100, 1'b0, 32'h0);
        push(32'h104, 1'b0, 32'h0);
        run3();

        // T4 allocate, predict taken, then train to not-taken
        btb_upd(32'h10, 1'b1, 32'h40);
        redirect(32'h10);
        push(32'h10, 1'b1, 32'h40);
        push(32'h40, 1'b0, 32'h0);
        run3();
        btb_upd(32'h10, 1'b0, 32'h0);
        btb_upd(32'h10, 1'b0, 32'h0);
        redirect(32'h10);
        push(32'h10, 1'b0, 32'h0);
        push(32'h14, 1'b0, 32'h0);
        run3();

        // T5 aliasing entry replaced by 0x50
        btb_upd(32'h10, 1'b1, 32'h90);
        btb_upd(32'h50, 1'b1, 32'h200);
        redirect(32'h10);
        push(32'h10, 1'b0, 32'h0);
        push(32'h14, 1'b0, 32'h0);
        run3();
        redirect(32'h50);
        push(32'h50, 1'b1, 32'h200);
        push(32'h200, 1'b0, 32'h0);
        run3();

        // T6 global freeze drops redirect and update
        rdy = 1'b0;
        f0.btb_upd_valid_in = 1'b1; f0.btb_upd_pc_in = 32'h20;
        f0.btb_upd_taken_in = 1'b1; f0.btb_upd_tar_in = 32'h300;
        f0.redirect_valid_in = 1'b1; f0.redirect_pc_in = 32'h500;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("frz_pc", f0.fetch_pc_out, 32'h204);
            check("frz_valid", 32'(f0.fetch_valid_out), 32'd1);
        end
        rdy = 1'b1;
        f0.btb_upd_valid_in = 1'b0;
        f0.redirect_valid_in = 1'b0;
        redirect(32'h20);
        push(32'h20, 1'b0, 32'h0);
        push(32'h24, 1'b0, 32'h0);
        run3();

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
